// File: rtl/sfx_pkg.sv
// Shared types, default sizing and the saturating clip used by the sound-effect sequencer.
package sfx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_RDY,
        ST_FETCH,
        ST_MIX,
        ST_WRITE,
        ST_ADVANCE
    } sfx_state_t;

    typedef enum logic [1:0] {
        BOUNCE,
        SCORE,
        LVL
    } voice_id_t;

    localparam int NUM_VOICES     = 3;
    localparam int DEF_SAMPLE_W   = 32;
    localparam int DEF_BOUNCE_LEN = 1024;
    localparam int DEF_SCORE_LEN  = 4096;
    localparam int DEF_LVL_LEN    = 2048;
    localparam int DEF_ROM_LAT    = 2;
    localparam int SAT_W          = 64;

    // Clips a sign-extended sum into the signed range of a width-bit sample (width <= 62).
    function automatic logic signed [SAT_W-1:0] sat_clip(
        input logic signed [SAT_W-1:0] sum,
        input int unsigned             width
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (sum > hi) begin
            return hi;
        end else if (sum < lo) begin
            return lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/sfx_voice.sv
// One playback voice: address counter, repeat count and active flag for a single sample ROM.
module sfx_voice
    import sfx_pkg::*;
#(
    parameter int LEN = DEF_BOUNCE_LEN
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [1:0]             start_plays,
    input  logic                   advance,
    output logic [$clog2(LEN)-1:0] addr,
    output logic                   active
);

    localparam int AW = $clog2(LEN);
    localparam logic [AW-1:0] LAST = AW'(LEN - 1);

    logic [1:0] plays;

    // A start always wins over the normal step, so a retrigger restarts from address 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr   <= '0;
            active <= 1'b0;
            plays  <= 2'd0;
        end else if (advance) begin
            if (start) begin
                addr   <= '0;
                active <= 1'b1;
                plays  <= start_plays;
            end else if (active) begin
                if (addr == LAST) begin
                    addr  <= '0;
                    plays <= plays - 2'd1;
                    if (plays == 2'd1) begin
                        active <= 1'b0;
                    end
                end else begin
                    addr <= addr + AW'(1);
                end
            end else begin
                addr <= '0;
            end
        end
    end

endmodule

// File: rtl/sfx_sequencer.sv
// Turns game event pulses into ROM playback, mixes the voices with saturation and feeds the codec.
module sfx_sequencer
    import sfx_pkg::*;
#(
    parameter int SAMPLE_W   = DEF_SAMPLE_W,
    parameter int BOUNCE_LEN = DEF_BOUNCE_LEN,
    parameter int SCORE_LEN  = DEF_SCORE_LEN,
    parameter int LVL_LEN    = DEF_LVL_LEN,
    parameter int ROM_LAT    = DEF_ROM_LAT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wall_hit,
    input  logic                          paddle_hit,
    input  logic                          point,
    input  logic                          win,
    input  logic                          lvl_up,
    input  logic                          write_ready,
    input  logic [SAMPLE_W-1:0]           bounce_q,
    input  logic [SAMPLE_W-1:0]           score_q,
    input  logic [SAMPLE_W-1:0]           lvl_q,
    output logic [$clog2(BOUNCE_LEN)-1:0] bounce_addr,
    output logic [$clog2(SCORE_LEN)-1:0]  score_addr,
    output logic [$clog2(LVL_LEN)-1:0]    lvl_addr,
    output logic                          write,
    output logic [SAMPLE_W-1:0]           writedata_left,
    output logic [SAMPLE_W-1:0]           writedata_right,
    output logic                          busy
);

    localparam int SUM_W = SAMPLE_W + 2;

    sfx_state_t state;
    sfx_state_t state_next;

    logic [1:0]            lat_cnt;
    logic                  lat_done;
    logic                  pend_bounce;
    logic                  pend_point;
    logic                  pend_win;
    logic                  pend_lvl;
    logic                  trig_bounce;
    logic                  trig_score;
    logic                  trig_win;
    logic                  trig_lvl;
    logic                  is_advance;
    logic [1:0]            score_plays;
    logic [NUM_VOICES-1:0] voice_active;
    logic [NUM_VOICES-1:0] voice_start;
    logic [SAMPLE_W-1:0]   sample_reg;
    logic [SAMPLE_W-1:0]   mix_sat;

    logic signed [SUM_W-1:0] bounce_ext;
    logic signed [SUM_W-1:0] score_ext;
    logic signed [SUM_W-1:0] lvl_ext;
    logic signed [SUM_W-1:0] mix_sum;

    assign lat_done   = (lat_cnt == 2'(ROM_LAT - 1));
    assign is_advance = (state == ST_ADVANCE);

    // Events raised during the ADVANCE cycle itself count immediately.
    assign trig_bounce = pend_bounce | wall_hit | paddle_hit;
    assign trig_win    = pend_win | win;
    assign trig_score  = trig_win | pend_point | point;
    assign trig_lvl    = pend_lvl | lvl_up;
    assign score_plays = trig_win ? 2'd2 : 2'd1;

    assign voice_start[BOUNCE] = is_advance & trig_bounce;
    assign voice_start[SCORE]  = is_advance & trig_score;
    assign voice_start[LVL]    = is_advance & trig_lvl;

    sfx_voice #(.LEN(BOUNCE_LEN)) u_bounce (
        .clk        (clk),
        .rst        (rst),
        .start      (voice_start[BOUNCE]),
        .start_plays(2'd1),
        .advance    (is_advance),
        .addr       (bounce_addr),
        .active     (voice_active[BOUNCE])
    );

    sfx_voice #(.LEN(SCORE_LEN)) u_score (
        .clk        (clk),
        .rst        (rst),
        .start      (voice_start[SCORE]),
        .start_plays(score_plays),
        .advance    (is_advance),
        .addr       (score_addr),
        .active     (voice_active[SCORE])
    );

    sfx_voice #(.LEN(LVL_LEN)) u_lvl (
        .clk        (clk),
        .rst        (rst),
        .start      (voice_start[LVL]),
        .start_plays(2'd1),
        .advance    (is_advance),
        .addr       (lvl_addr),
        .active     (voice_active[LVL])
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:     state_next = ST_WAIT_RDY;
            ST_WAIT_RDY: if (write_ready) state_next = ST_FETCH;
            ST_FETCH:    if (lat_done) state_next = ST_MIX;
            ST_MIX:      state_next = ST_WRITE;
            ST_WRITE:    if (write_ready) state_next = ST_ADVANCE;
            ST_ADVANCE:  state_next = ST_WAIT_RDY;
            default:     state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        write = (state == ST_WRITE) && write_ready;
    end

    assign bounce_ext = {{2{bounce_q[SAMPLE_W-1]}}, bounce_q};
    assign score_ext  = {{2{score_q[SAMPLE_W-1]}}, score_q};
    assign lvl_ext    = {{2{lvl_q[SAMPLE_W-1]}}, lvl_q};

    always_comb begin
        mix_sum = '0;
        if (voice_active[BOUNCE]) mix_sum = mix_sum + bounce_ext;
        if (voice_active[SCORE])  mix_sum = mix_sum + score_ext;
        if (voice_active[LVL])    mix_sum = mix_sum + lvl_ext;
        mix_sat = SAMPLE_W'(sat_clip(SAT_W'(mix_sum), SAMPLE_W));
    end

    // FETCH holds the addresses for ROM_LAT clocks; the counter restarts outside FETCH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_cnt    <= 2'd0;
            sample_reg <= '0;
        end else begin
            lat_cnt <= (state == ST_FETCH) ? lat_cnt + 2'd1 : 2'd0;
            if (state == ST_MIX) begin
                sample_reg <= mix_sat;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_bounce <= 1'b0;
            pend_point  <= 1'b0;
            pend_win    <= 1'b0;
            pend_lvl    <= 1'b0;
        end else if (is_advance) begin
            pend_bounce <= 1'b0;
            pend_point  <= 1'b0;
            pend_win    <= 1'b0;
            pend_lvl    <= 1'b0;
        end else begin
            pend_bounce <= trig_bounce;
            pend_point  <= pend_point | point;
            pend_win    <= trig_win;
            pend_lvl    <= trig_lvl;
        end
    end

    assign writedata_left  = sample_reg;
    assign writedata_right = sample_reg;
    assign busy            = |voice_active;

endmodule

// File: tb/tb_sfx_sequencer.sv
// Directed bench for sfx_sequencer with latency-accurate ROM models whose contents are selectable.
module tb_sfx_sequencer;

    localparam int SW  = 32;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          wall_hit;
    logic          paddle_hit;
    logic          point;
    logic          win;
    logic          lvl_up;
    logic          write_ready;
    logic [SW-1:0] bounce_q;
    logic [SW-1:0] score_q;
    logic [SW-1:0] lvl_q;
    logic [9:0]    bounce_addr;
    logic [11:0]   score_addr;
    logic [10:0]   lvl_addr;
    logic          write;
    logic [SW-1:0] writedata_left;
    logic [SW-1:0] writedata_right;
    logic          busy;

    int            checks = 0;
    int            failures = 0;
    int            write_count = 0;
    int            strobe_bad = 0;
    int            lr_bad = 0;
    int            rom_mode = 0;
    logic          prev_write = 1'b0;
    logic [SW-1:0] last_data = '0;
    logic [9:0]    last_b = '0;
    logic [11:0]   last_s = '0;
    logic [10:0]   last_l = '0;

    logic [SW-1:0] b_pipe [LAT];
    logic [SW-1:0] s_pipe [LAT];
    logic [SW-1:0] l_pipe [LAT];

    sfx_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .wall_hit       (wall_hit),
        .paddle_hit     (paddle_hit),
        .point          (point),
        .win            (win),
        .lvl_up         (lvl_up),
        .write_ready    (write_ready),
        .bounce_q       (bounce_q),
        .score_q        (score_q),
        .lvl_q          (lvl_q),
        .bounce_addr    (bounce_addr),
        .score_addr     (score_addr),
        .lvl_addr       (lvl_addr),
        .write          (write),
        .writedata_left (writedata_left),
        .writedata_right(writedata_right),
        .busy           (busy)
    );

    always #10 clk = ~clk;

    // Mode 0: word equals address; 1: positive full scale; 2: negative full scale.
    function automatic logic [SW-1:0] rom_word(input int mode, input logic [11:0] addr);
        if (mode == 0) return {20'd0, addr};
        if (mode == 1) return 32'h7FFF_FFFF;
        return 32'h8000_0000;
    endfunction

    always @(posedge clk) begin
        b_pipe[0] <= rom_word(rom_mode, {2'b00, bounce_addr});
        s_pipe[0] <= rom_word(rom_mode, score_addr);
        l_pipe[0] <= rom_word(rom_mode, {1'b0, lvl_addr});
        for (int i = 1; i < LAT; i++) begin
            b_pipe[i] <= b_pipe[i-1];
            s_pipe[i] <= s_pipe[i-1];
            l_pipe[i] <= l_pipe[i-1];
        end
    end

    assign bounce_q = b_pipe[LAT-1];
    assign score_q  = s_pipe[LAT-1];
    assign lvl_q    = l_pipe[LAT-1];

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Samples mid-cycle, then returns just after the next rising edge so callers drive inputs there.
    task automatic tick();
        @(negedge clk);
        if (write) begin
            write_count++;
            last_data = writedata_left;
            last_b    = bounce_addr;
            last_s    = score_addr;
            last_l    = lvl_addr;
            if (writedata_right !== writedata_left) lr_bad++;
            if (!write_ready) strobe_bad++;
            if (prev_write) strobe_bad++;
        end
        prev_write = write;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [4:0] ev);
        {wall_hit, paddle_hit, point, win, lvl_up} = ev;
        tick();
        {wall_hit, paddle_hit, point, win, lvl_up} = 5'b0;
    endtask

    task automatic wait_write();
        int start;
        int n;
        start = write_count;
        n = 0;
        while (write_count == start && n < 200) begin
            tick();
            n++;
        end
        if (write_count == start) checkOutput("write_timeout", 64'(0), 64'(1));
    endtask

    task automatic wait_busy(input logic level);
        int n;
        n = 0;
        while (busy !== level && n < 200) begin
            tick();
            n++;
        end
        checkOutput("busy_wait", 64'(busy), 64'(level));
    endtask

    initial begin
        int w0;
        int n;
        rst = 1'b0;
        write_ready = 1'b0;
        {wall_hit, paddle_hit, point, win, lvl_up} = 5'b0;

        repeat (3) tick();
        checkOutput("rst_write", 64'(write), 64'(0));
        checkOutput("rst_data", 64'(writedata_left), 64'(0));
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_addr", 64'({bounce_addr, score_addr, lvl_addr}), 64'(0));
        rst = 1'b1;

        // Silence with sparse ready pulses: a sample completes on every second pulse.
        w0 = write_count;
        for (int i = 0; i < 240; i++) begin
            write_ready = (i % 20 == 0);
            tick();
            if (write_count != w0) checkOutput("silence_data", 64'(last_data), 64'(0));
        end
        checkOutput("silence_writes", 64'(write_count - w0), 64'(5));
        checkOutput("silence_busy", 64'(busy), 64'(0));
        checkOutput("silence_addr", 64'({bounce_addr, score_addr, lvl_addr}), 64'(0));
        write_ready = 1'b1;

        applyStimulus(5'b01000);
        wait_busy(1'b1);
        for (int i = 0; i < 1024; i++) begin
            wait_write();
            checkOutput($sformatf("bounce_seq[%0d]", i), 64'(last_data), 64'(i));
        end
        checkOutput("bounce_addr_last", 64'(last_b), 64'(1023));
        tick();
        checkOutput("bounce_busy_end", 64'(busy), 64'(0));
        checkOutput("bounce_addr_end", 64'(bounce_addr), 64'(0));
        wait_write();
        checkOutput("bounce_after", 64'(last_data), 64'(0));

        // Simultaneous point and win: win's two plays must survive.
        applyStimulus(5'b00110);
        wait_busy(1'b1);
        for (int i = 0; i < 8192; i++) begin
            wait_write();
            checkOutput($sformatf("win_seq[%0d]", i), 64'(last_data), 64'(i % 4096));
        end
        tick();
        checkOutput("win_busy_end", 64'(busy), 64'(0));

        rom_mode = 1;
        applyStimulus(5'b10101);
        wait_busy(1'b1);
        wait_write();
        checkOutput("sat_pos", 64'(last_data), 64'(32'h7FFF_FFFF));
        rom_mode = 2;
        wait_write();
        wait_write();
        checkOutput("sat_neg", 64'(last_data), 64'(32'h8000_0000));
        rom_mode = 0;

        n = 0;
        while (last_b != 10'd500 && n < 600) begin
            wait_write();
            n++;
        end
        checkOutput("retrig_reach", 64'(last_b), 64'(500));
        applyStimulus(5'b10000);
        wait_write();
        checkOutput("retrig_baddr", 64'(last_b), 64'(0));
        checkOutput("retrig_saddr", 64'(last_s), 64'(501));
        checkOutput("retrig_data", 64'(last_data), 64'(1002));

        wait_write();
        checkOutput("pre_stall_data", 64'(last_data), 64'(1005));
        repeat (5) tick();
        write_ready = 1'b0;
        w0 = write_count;
        repeat (10) tick();
        checkOutput("stall_writes", 64'(write_count - w0), 64'(0));
        checkOutput("stall_write", 64'(write), 64'(0));
        checkOutput("stall_saddr", 64'(score_addr), 64'(503));
        write_ready = 1'b1;
        wait_write();
        checkOutput("stall_data", 64'(last_data), 64'(1008));
        wait_write();
        checkOutput("post_stall_data", 64'(last_data), 64'(1011));

        n = 0;
        while (last_l != 11'd699 && n < 300) begin
            wait_write();
            n++;
        end
        repeat (2) tick();
        checkOutput("mid_lvl_addr", 64'(lvl_addr), 64'(700));
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_write", 64'(write), 64'(0));
        checkOutput("mid_rst_data", 64'(writedata_left), 64'(0));
        checkOutput("mid_rst_busy", 64'(busy), 64'(0));
        checkOutput("mid_rst_addr", 64'({bounce_addr, score_addr, lvl_addr}), 64'(0));
        repeat (2) tick();
        rst = 1'b1;
        wait_write();
        checkOutput("post_rst_data", 64'(last_data), 64'(0));
        checkOutput("post_rst_busy", 64'(busy), 64'(0));

        checkOutput("strobe_rules", 64'(strobe_bad), 64'(0));
        checkOutput("left_right", 64'(lr_bad), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
